// File: rtl/pkt_len_filter.sv
// Store-and-forward length guard: buffers one packet of up to MAX_PKT_LEN words, forwards only complete, fitting packets.
// Latency: first output beat is valid the cycle after the EOP beat is accepted; then 1 word/cycle while src_ready_i is high.
// Backpressure: snk_ready_o drops for the whole output phase; output registers hold while src_valid_o && !src_ready_i.
//
// Ports:
//   clk_i, srst_i         clock (rising edge) and synchronous active-high reset
//   snk_*                 Avalon-ST sink (data, startofpacket, endofpacket, valid, ready)
//   src_*                 Avalon-ST source, all outputs registered except none combinational
//   drop_cnt_o            saturating count of dropped packets (overflow or restart),
//                         present only when PKT_LEN_FILTER_STATS_EN is defined
module pkt_len_filter #(
    parameter int DWIDTH      = 16,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i
`ifdef PKT_LEN_FILTER_STATS_EN
    ,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam int AW = $clog2(MAX_PKT_LEN);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_PKT_LEN);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DWIDTH-1:0] mem [MAX_PKT_LEN];
    logic [CW-1:0]     wr_cnt;
    logic [CW-1:0]     rd_cnt;
    logic [CW-1:0]     len;

    logic acc;         // sink beat accepted this cycle
    logic start_pkt;   // SOP accepted: word goes to mem[0], any partial packet is abandoned
    logic append;      // non-SOP beat stored at mem[wr_cnt]
    logic enter_send;  // EOP of a keepable packet accepted; output registers load now
    logic out_pop;     // current output beat consumed downstream

    assign snk_ready_o = (state != SEND);
    assign acc         = snk_valid_i && snk_ready_o;
    assign out_pop     = (state == SEND) && src_valid_o && src_ready_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        start_pkt  = 1'b0;
        append     = 1'b0;
        enter_send = 1'b0;
        case (state)
            IDLE, DROP: begin
                if (acc) begin
                    if (snk_startofpacket_i) begin
                        // SOP wins over EOP on the same beat, including in DROP
                        start_pkt  = 1'b1;
                        enter_send = snk_endofpacket_i;
                        state_nxt  = snk_endofpacket_i ? SEND : RECV;
                    end else if ((state == DROP) && snk_endofpacket_i) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RECV: begin
                if (acc) begin
                    if (snk_startofpacket_i) begin
                        start_pkt  = 1'b1;
                        enter_send = snk_endofpacket_i;
                        state_nxt  = snk_endofpacket_i ? SEND : RECV;
                    end else if (wr_cnt < MAX_C) begin
                        append = 1'b1;
                        if (snk_endofpacket_i) begin
                            enter_send = 1'b1;
                            state_nxt  = SEND;
                        end
                    end else begin
                        // buffer already full: this beat makes the packet oversize
                        state_nxt = snk_endofpacket_i ? IDLE : DROP;
                    end
                end
            end
            SEND: begin
                if (out_pop && src_endofpacket_o) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Packet buffer (contents need no reset; validity is tracked by state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (start_pkt) begin
            mem[0] <= snk_data_i;
        end else if (append) begin
            mem[wr_cnt[AW-1:0]] <= snk_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Counters and registered source interface
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_cnt              <= '0;
            rd_cnt              <= '0;
            len                 <= '0;
            src_data_o          <= '0;
            src_valid_o         <= 1'b0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
        end else begin
            if (start_pkt) begin
                wr_cnt <= ONE_C;
            end else if (append) begin
                wr_cnt <= wr_cnt + ONE_C;
            end

            if (enter_send) begin
                // A single-beat packet is written to mem[0] on this same edge,
                // so its word is taken straight from the sink bus.
                len                 <= start_pkt ? ONE_C : (wr_cnt + ONE_C);
                src_data_o          <= start_pkt ? snk_data_i : mem[0];
                src_valid_o         <= 1'b1;
                src_startofpacket_o <= 1'b1;
                src_endofpacket_o   <= start_pkt;
                rd_cnt              <= ONE_C;
            end else if (out_pop) begin
                if (src_endofpacket_o) begin
                    src_valid_o         <= 1'b0;
                    src_startofpacket_o <= 1'b0;
                    src_endofpacket_o   <= 1'b0;
                end else begin
                    src_data_o          <= mem[rd_cnt[AW-1:0]];
                    src_startofpacket_o <= 1'b0;
                    src_endofpacket_o   <= (rd_cnt == (len - ONE_C));
                    rd_cnt              <= rd_cnt + ONE_C;
                end
            end
        end
    end

`ifdef PKT_LEN_FILTER_STATS_EN
    // A packet is lost either on overflow or when a new SOP restarts a partial one.
    logic drop_evt;
    assign drop_evt = acc && (state == RECV) &&
                      (snk_startofpacket_i || (wr_cnt == MAX_C));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            drop_cnt_o <= '0;
        end else if (drop_evt && (drop_cnt_o != 16'hFFFF)) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_len_filter.sv
module tb_pkt_len_filter;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] snk_data_i;
    logic        snk_startofpacket_i;
    logic        snk_endofpacket_i;
    logic        snk_valid_i;
    logic        snk_ready_o;
    logic [15:0] src_data_o;
    logic        src_startofpacket_o;
    logic        src_endofpacket_o;
    logic        src_valid_o;
    logic        src_ready_i;
`ifdef PKT_LEN_FILTER_STATS_EN
    logic [15:0] drop_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pkt_len_filter #(.DWIDTH(16), .MAX_PKT_LEN(16)) dut (
        .clk_i               (clk_i),
        .srst_i              (srst_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i)
`ifdef PKT_LEN_FILTER_STATS_EN
        ,
        .drop_cnt_o          (drop_cnt_o)
`endif
    );

    typedef struct {
        logic        sop, eop, vld;
        logic [15:0] dat;
        logic        rdy;
        logic        e_vld, e_sop, e_eop;
        logic [15:0] e_dat;
        logic        e_srdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic sop, eop, vld, input logic [15:0] dat,
                                input logic rdy, e_vld, e_sop, e_eop,
                                input logic [15:0] e_dat, input logic e_srdy);
        vec_t v;
        v.sop = sop; v.eop = eop; v.vld = vld; v.dat = dat; v.rdy = rdy;
        v.e_vld = e_vld; v.e_sop = e_sop; v.e_eop = e_eop; v.e_dat = e_dat; v.e_srdy = e_srdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
        snk_data_i = 16'h0;
    endtask

    // Drive n beats; until the forwarded last beat, the guard must stay silent and ready.
    task automatic send_pkt(input int n, input logic [15:0] base, input logic eop_last,
                            input logic fwd, input string name);
        logic quiet;
        quiet = 1'b1;
        for (int i = 0; i < n; i++) begin
            snk_valid_i = 1'b1;
            snk_startofpacket_i = (i == 0);
            snk_endofpacket_i = eop_last && (i == n - 1);
            snk_data_i = base + 16'(i);
            step();
            if (!(fwd && i == n - 1) && (src_valid_o || !snk_ready_o)) quiet = 1'b0;
        end
        idle_in();
        chk(name, {31'h0, quiet}, 32'h1);
    endtask

    // Consume n beats base, base+1, ... with src_ready_i high, bounded wait.
    task automatic collect(input int n, input logic [15:0] base, input string name);
        int got;
        got = 0;
        src_ready_i = 1'b1;
        for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
            if (src_valid_o) begin
                chk($sformatf("%s_beat%0d", name, got),
                    {14'h0, src_startofpacket_o, src_endofpacket_o, src_data_o},
                    {14'h0, (got == 0), (got == n - 1), base + 16'(got)});
                got++;
            end
            step();
        end
        chk($sformatf("%s_count", name), got, n);
        chk($sformatf("%s_done", name), {30'h0, src_valid_o, snk_ready_o}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // sop eop vld dat rdy | e_vld e_sop e_eop e_dat e_srdy
        // 4-word packet, back-to-back output
        tbl.push_back(mk(1,0,1,16'h000A,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,0,1,16'h000B,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,0,1,16'h000C,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,1,1,16'h000D,1, 1,1,0,16'h000A,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 1,0,0,16'h000B,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 1,0,0,16'h000C,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 1,0,1,16'h000D,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 0,0,0,16'h0000,1));
        // single-beat packet
        tbl.push_back(mk(1,1,1,16'h1234,1, 1,1,1,16'h1234,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 0,0,0,16'h0000,1));
        // orphans 5,6 then packet 7,8
        tbl.push_back(mk(0,0,1,16'h0005,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,0,1,16'h0006,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(1,0,1,16'h0007,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,1,1,16'h0008,1, 1,1,0,16'h0007,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 1,0,1,16'h0008,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 0,0,0,16'h0000,1));
        // restart: SOP,1,2 then SOP+EOP 9
        tbl.push_back(mk(1,0,1,16'h0011,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,0,1,16'h0001,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,0,1,16'h0002,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(1,1,1,16'h0009,1, 1,1,1,16'h0009,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 0,0,0,16'h0000,1));
        // 3-word packet, ready 1,0,0,1,1 during output; sink beat offered while not ready
        tbl.push_back(mk(1,0,1,16'h0021,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,0,1,16'h0022,1, 0,0,0,16'h0000,1));
        tbl.push_back(mk(0,1,1,16'h0023,1, 1,1,0,16'h0021,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 1,0,0,16'h0022,0));
        tbl.push_back(mk(1,1,1,16'h0BAD,0, 1,0,0,16'h0022,0));
        tbl.push_back(mk(0,0,0,16'h0000,0, 1,0,0,16'h0022,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 1,0,1,16'h0023,0));
        tbl.push_back(mk(0,0,0,16'h0000,1, 0,0,0,16'h0000,1));

        srst_i = 1'b1;
        src_ready_i = 1'b1;
        idle_in();
        step();
        step();
        srst_i = 1'b0;
        chk("reset_outputs",
            {12'h0, src_valid_o, src_startofpacket_o, src_endofpacket_o, snk_ready_o, src_data_o},
            {12'h0, 4'b0001, 16'h0000});
        step();
        chk("reset_ready", {31'h0, snk_ready_o}, 32'h1);

        foreach (tbl[i]) begin
            snk_startofpacket_i = tbl[i].sop;
            snk_endofpacket_i   = tbl[i].eop;
            snk_valid_i         = tbl[i].vld;
            snk_data_i          = tbl[i].dat;
            src_ready_i         = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d", i),
                {12'h0, src_valid_o, src_startofpacket_o, src_endofpacket_o, snk_ready_o,
                 src_valid_o ? src_data_o : 16'h0},
                {12'h0, tbl[i].e_vld, tbl[i].e_sop, tbl[i].e_eop, tbl[i].e_srdy,
                 tbl[i].e_vld ? tbl[i].e_dat : 16'h0});
        end
        idle_in();
        src_ready_i = 1'b1;
`ifdef PKT_LEN_FILTER_STATS_EN
        chk("drop_cnt_restart", {16'h0, drop_cnt_o}, 32'd1);
`endif

        // 17 words with EOP: dropped straight back to IDLE
        send_pkt(17, 16'h0200, 1'b1, 1'b0, "ovf17_quiet");
        // 18 words without EOP: parks in DROP; next SOP restarts there
        send_pkt(18, 16'h0280, 1'b0, 1'b0, "ovf18_quiet");
        // exactly MAX_PKT_LEN words is forwarded intact
        send_pkt(16, 16'h0300, 1'b1, 1'b1, "max16_quiet");
        collect(16, 16'h0300, "max16");
`ifdef PKT_LEN_FILTER_STATS_EN
        chk("drop_cnt_ovf", {16'h0, drop_cnt_o}, 32'd3);
`endif

        // reset in the middle of a held output beat
        src_ready_i = 1'b0;
        send_pkt(3, 16'h0400, 1'b1, 1'b1, "rst_pkt_quiet");
        step();
        chk("hold_before_rst",
            {13'h0, src_valid_o, src_startofpacket_o, src_endofpacket_o, src_data_o},
            {13'h0, 3'b110, 16'h0400});
        srst_i = 1'b1;
        step();
        srst_i = 1'b0;
        chk("mid_output_rst",
            {28'h0, src_valid_o, src_startofpacket_o, src_endofpacket_o, snk_ready_o},
            32'h1);
`ifdef PKT_LEN_FILTER_STATS_EN
        chk("drop_cnt_rst", {16'h0, drop_cnt_o}, 32'd0);
`endif
        src_ready_i = 1'b1;
        snk_valid_i = 1'b1; snk_startofpacket_i = 1'b1; snk_endofpacket_i = 1'b1;
        snk_data_i = 16'h55AA;
        step();
        idle_in();
        collect(1, 16'h55AA, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
